mem_load_align_q: RTL and testbench

Queued, parametrised load-result unit for the memory stage. It records each issued load's metadata in an in-order queue and pairs it with the data response from the data cache or bus when that response arrives a variable number of cycles later. It then extracts, sign- or zero-extends, and merges the loaded value (LB/LBU/LH/LHU/LW/LWL/LWR), checks alignment, and presents the result to writeback through a registered valid/ready stage. A flush discards all in-flight loads, including responses still to arrive.

---
 rtl/mem_load_align_q_if.sv | 45 ++++
 rtl/mem_load_align_q.sv | 158 +++++++++++++++
 tb/tb_mem_load_align_q.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_load_align_q_if.sv
// Load issue, memory response and writeback handshake bundle for mem_load_align_q.
// master = pipeline/memory side, slave = the load-result unit.
interface mem_load_align_q_if #(
  parameter int DATA_W = 32,
  parameter int OFS_W  = $clog2(DATA_W / 8)
);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [OFS_W-1:0]  req_offset;
  logic [31:0]       req_old;
  logic [4:0]        req_wreg;
  logic              req_dslot;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_data;
  logic              resp_err;

  logic              wb_valid;
  logic              wb_ready;
  logic [31:0]       wb_data;
  logic [4:0]        wb_wreg;
  logic              wb_we;
  logic              wb_err;
  logic              wb_dslot;

  modport master (
    output req_valid, req_op, req_offset, req_old, req_wreg, req_dslot,
    input  req_ready,
    output resp_valid, resp_data, resp_err,
    input  resp_ready,
    input  wb_valid, wb_data, wb_wreg, wb_we, wb_err, wb_dslot,
    output wb_ready
  );

  modport slave (
    input  req_valid, req_op, req_offset, req_old, req_wreg, req_dslot,
    output req_ready,
    input  resp_valid, resp_data, resp_err,
    output resp_ready,
    output wb_valid, wb_data, wb_wreg, wb_we, wb_err, wb_dslot,
    input  wb_ready
  );
endinterface

// File: rtl/mem_load_align_q.sv
// In-order load metadata queue paired with delayed memory responses; extracts,
// extends and merges the loaded value and presents it through a registered wb stage.
module mem_load_align_q #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int OFS_W  = $clog2(DATA_W / 8)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  mem_load_align_q_if.slave            bus,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [2:0]       q_op    [DEPTH];
  logic [OFS_W-1:0] q_ofs   [DEPTH];
  logic [31:0]      q_old   [DEPTH];
  logic [4:0]       q_wreg  [DEPTH];
  logic             q_dslot [DEPTH];

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W:0]   occupied;

  logic push, resp_hs, drop_hs, pop;

  logic [2:0]       h_op;
  logic [OFS_W-1:0] h_ofs;
  logic [31:0]      h_old;
  logic [1:0]       b;
  logic [31:0]      w;
  logic [7:0]       bsel;
  logic [15:0]      hsel;
  logic [31:0]      res;
  logic             mis;
  logic             err;

  assign occupied       = {1'b0, count} + {1'b0, drop_cnt};
  assign bus.req_ready  = !flush && (occupied < (CNT_W + 1)'(DEPTH));
  assign bus.resp_ready = (drop_cnt != '0) ||
                          (count != '0 && (!bus.wb_valid || bus.wb_ready));

  assign push    = bus.req_valid && bus.req_ready;
  assign resp_hs = bus.resp_valid && bus.resp_ready;
  assign drop_hs = resp_hs && (drop_cnt != '0);
  assign pop     = resp_hs && (drop_cnt == '0);

  assign h_op  = q_op[rd_ptr];
  assign h_ofs = q_ofs[rd_ptr];
  assign h_old = q_old[rd_ptr];
  assign b     = h_ofs[1:0];

  generate
    if (DATA_W == 64) begin : g_lane64
      assign w = h_ofs[2] ? bus.resp_data[63:32] : bus.resp_data[31:0];
    end else begin : g_lane32
      assign w = bus.resp_data[31:0];
    end
  endgenerate

  always_comb begin
    res  = w;
    mis  = 1'b0;
    bsel = w[{b, 3'b000} +: 8];
    hsel = b[1] ? w[31:16] : w[15:0];
    case (h_op)
      3'd0, 3'd1: res = {{24{!h_op[0] && bsel[7]}}, bsel};
      3'd2, 3'd3: begin
        res = {{16{!h_op[0] && hsel[15]}}, hsel};
        mis = b[0];
      end
      3'd5: begin
        case (b)
          2'd3:    res = w;
          2'd2:    res = {w[23:0], h_old[7:0]};
          2'd1:    res = {w[15:0], h_old[15:0]};
          default: res = {w[7:0],  h_old[23:0]};
        endcase
      end
      3'd6: begin
        case (b)
          2'd0:    res = w;
          2'd1:    res = {h_old[31:24], w[31:8]};
          2'd2:    res = {h_old[31:16], w[31:16]};
          default: res = {h_old[31:8],  w[31:24]};
        endcase
      end
      default: begin
        res = w;
        mis = (b != 2'd0);
      end
    endcase
    err = mis || bus.resp_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_op[i]    <= '0;
        q_ofs[i]   <= '0;
        q_old[i]   <= '0;
        q_wreg[i]  <= '0;
        q_dslot[i] <= 1'b0;
      end
    end else if (push) begin
      q_op[wr_ptr]    <= bus.req_op;
      q_ofs[wr_ptr]   <= bus.req_offset;
      q_old[wr_ptr]   <= bus.req_old;
      q_wreg[wr_ptr]  <= bus.req_wreg;
      q_dslot[wr_ptr] <= bus.req_dslot;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
    end else if (flush) begin
      // Every live entry still owes a response; those become drops.
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= drop_cnt + count - CNT_W'(resp_hs);
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
      if (drop_hs) drop_cnt <= drop_cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wb_valid <= 1'b0;
      bus.wb_data  <= '0;
      bus.wb_wreg  <= '0;
      bus.wb_we    <= 1'b0;
      bus.wb_err   <= 1'b0;
      bus.wb_dslot <= 1'b0;
    end else if (flush) begin
      bus.wb_valid <= 1'b0;
    end else if (pop) begin
      bus.wb_valid <= 1'b1;
      bus.wb_data  <= err ? 32'd0 : res;
      bus.wb_wreg  <= q_wreg[rd_ptr];
      bus.wb_we    <= !err;
      bus.wb_err   <= err;
      bus.wb_dslot <= q_dslot[rd_ptr];
    end else if (bus.wb_ready) begin
      bus.wb_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mem_load_align_q.sv
// Directed bench driving a 32-bit and a 64-bit instance in lockstep from one stimulus
// stream; the 32-bit instance sees offset[1:0] and resp_data[31:0].
module tb_mem_load_align_q;
  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic [2:0]  req_op;
  logic [2:0]  req_offset;
  logic [31:0] req_old;
  logic [4:0]  req_wreg;
  logic        req_dslot;
  logic        resp_valid;
  logic [63:0] resp_data;
  logic        resp_err;
  logic        wb_ready;
  logic [2:0]  cnt32, cnt64;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mem_load_align_q_if #(.DATA_W(32)) b32 ();
  mem_load_align_q_if #(.DATA_W(64)) b64 ();

  assign b32.req_valid  = req_valid;
  assign b32.req_op     = req_op;
  assign b32.req_offset = req_offset[1:0];
  assign b32.req_old    = req_old;
  assign b32.req_wreg   = req_wreg;
  assign b32.req_dslot  = req_dslot;
  assign b32.resp_valid = resp_valid;
  assign b32.resp_data  = resp_data[31:0];
  assign b32.resp_err   = resp_err;
  assign b32.wb_ready   = wb_ready;

  assign b64.req_valid  = req_valid;
  assign b64.req_op     = req_op;
  assign b64.req_offset = req_offset;
  assign b64.req_old    = req_old;
  assign b64.req_wreg   = req_wreg;
  assign b64.req_dslot  = req_dslot;
  assign b64.resp_valid = resp_valid;
  assign b64.resp_data  = resp_data;
  assign b64.resp_err   = resp_err;
  assign b64.wb_ready   = wb_ready;

  mem_load_align_q #(.DATA_W(32), .DEPTH(4)) dut32 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b32), .count(cnt32));
  mem_load_align_q #(.DATA_W(64), .DEPTH(4)) dut64 (
    .clk(clk), .rst(rst), .flush(flush), .bus(b64), .count(cnt64));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [31:0] o32, input logic [31:0] o64,
                      input logic [31:0] exp);
    chk({tag, "/32"}, o32, exp);
    chk({tag, "/64"}, o64, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] ofs, input logic [31:0] old,
                       input logic [4:0] wreg, input logic dslot);
    req_valid = 1'b1; req_op = op; req_offset = ofs; req_old = old;
    req_wreg = wreg; req_dslot = dslot;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic respond(input logic [63:0] data, input logic err);
    resp_valid = 1'b1; resp_data = data; resp_err = err;
    tick();
    resp_valid = 1'b0; resp_err = 1'b0;
  endtask

  task automatic load_check(input string tag, input logic [2:0] op, input logic [2:0] ofs,
                            input logic [31:0] old, input logic [4:0] wreg, input logic dslot,
                            input logic [63:0] data, input logic rerr,
                            input logic [31:0] e32, input logic [31:0] e64, input logic eerr);
    issue(op, ofs, old, wreg, dslot);
    respond(data, rerr);
    chk2({tag, " valid"}, 32'(b32.wb_valid), 32'(b64.wb_valid), 32'd1);
    chk({tag, " data/32"}, b32.wb_data, e32);
    chk({tag, " data/64"}, b64.wb_data, e64);
    chk2({tag, " err"}, 32'(b32.wb_err), 32'(b64.wb_err), 32'(eerr));
    chk2({tag, " we"}, 32'(b32.wb_we), 32'(b64.wb_we), 32'(!eerr));
    chk2({tag, " wreg"}, 32'(b32.wb_wreg), 32'(b64.wb_wreg), 32'(wreg));
    chk2({tag, " dslot"}, 32'(b32.wb_dslot), 32'(b64.wb_dslot), 32'(dslot));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; req_op = '0; req_offset = '0;
    req_old = '0; req_wreg = '0; req_dslot = 1'b0; resp_valid = 1'b0;
    resp_data = '0; resp_err = 1'b0; wb_ready = 1'b1;
    #1;
    chk2("rst req_ready", 32'(b32.req_ready), 32'(b64.req_ready), 32'd1);
    chk2("rst resp_ready", 32'(b32.resp_ready), 32'(b64.resp_ready), 32'd0);
    chk2("rst wb_valid", 32'(b32.wb_valid), 32'(b64.wb_valid), 32'd0);
    chk2("rst wb_data", b32.wb_data, b64.wb_data, 32'd0);
    chk2("rst wb_flags", {b32.wb_wreg, b32.wb_we, b32.wb_err, b32.wb_dslot},
         {b64.wb_wreg, b64.wb_we, b64.wb_err, b64.wb_dslot}, 32'd0);
    chk2("rst count", 32'(cnt32), 32'(cnt64), 32'd0);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Sign / zero extension
    load_check("lb1",  3'd0, 3'd1, 32'h0, 5'd1, 1'b0, 64'h8899AABB, 1'b0,
               32'hFFFFFFAA, 32'hFFFFFFAA, 1'b0);
    load_check("lbu3", 3'd1, 3'd3, 32'h0, 5'd2, 1'b1, 64'h8899AABB, 1'b0,
               32'h00000088, 32'h00000088, 1'b0);
    load_check("lh2",  3'd2, 3'd2, 32'h0, 5'd3, 1'b0, 64'h8899AABB, 1'b0,
               32'hFFFF8899, 32'hFFFF8899, 1'b0);
    load_check("lhu0", 3'd3, 3'd0, 32'h0, 5'd4, 1'b0, 64'h8899AABB, 1'b0,
               32'h0000AABB, 32'h0000AABB, 1'b0);
    // Merges
    load_check("lwl1", 3'd5, 3'd1, 32'h11223344, 5'd5, 1'b0, 64'hAABBCCDD, 1'b0,
               32'hCCDD3344, 32'hCCDD3344, 1'b0);
    load_check("lwr2", 3'd6, 3'd2, 32'h11223344, 5'd6, 1'b0, 64'hAABBCCDD, 1'b0,
               32'h1122AABB, 32'h1122AABB, 1'b0);
    load_check("lwr0", 3'd6, 3'd0, 32'h11223344, 5'd7, 1'b0, 64'hAABBCCDD, 1'b0,
               32'hAABBCCDD, 32'hAABBCCDD, 1'b0);
    // Lane select: 32-bit copy sees offset 0 of 0x80000000 for the first case
    load_check("lb4",  3'd0, 3'd4, 32'h0, 5'd8, 1'b0, 64'h1234567880000000, 1'b0,
               32'h00000000, 32'h00000078, 1'b0);
    load_check("lb3",  3'd0, 3'd3, 32'h0, 5'd9, 1'b0, 64'h1234567880000000, 1'b0,
               32'hFFFFFF80, 32'hFFFFFF80, 1'b0);
    // Errors
    load_check("lw2",  3'd4, 3'd2, 32'h0, 5'd10, 1'b0, 64'hDEADBEEF, 1'b0,
               32'h0, 32'h0, 1'b1);
    load_check("lh1",  3'd2, 3'd1, 32'h0, 5'd11, 1'b0, 64'hDEADBEEF, 1'b0,
               32'h0, 32'h0, 1'b1);
    load_check("lwbe", 3'd4, 3'd0, 32'h0, 5'd12, 1'b0, 64'hDEADBEEF, 1'b1,
               32'h0, 32'h0, 1'b1);
    tick();

    // Full queue and backpressure
    wb_ready = 1'b0;
    for (int i = 1; i <= 4; i++) issue(3'd4, 3'd0, 32'h0, 5'(i), 1'b0);
    chk2("full req_ready", 32'(b32.req_ready), 32'(b64.req_ready), 32'd0);
    chk2("full count", 32'(cnt32), 32'(cnt64), 32'd4);
    resp_valid = 1'b1; resp_data = 64'h11111111;
    #1;
    chk2("bp resp_ready0", 32'(b32.resp_ready), 32'(b64.resp_ready), 32'd1);
    tick();
    chk2("bp data1", b32.wb_data, b64.wb_data, 32'h11111111);
    chk2("bp resp_ready1", 32'(b32.resp_ready), 32'(b64.resp_ready), 32'd0);
    chk2("bp count3", 32'(cnt32), 32'(cnt64), 32'd3);
    resp_data = 64'h22222222;
    tick();
    chk2("bp hold data", b32.wb_data, b64.wb_data, 32'h11111111);
    chk2("bp hold wreg", 32'(b32.wb_wreg), 32'(b64.wb_wreg), 32'd1);
    chk2("bp hold count", 32'(cnt32), 32'(cnt64), 32'd3);
    wb_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      tick();
      chk2("b2b valid", 32'(b32.wb_valid), 32'(b64.wb_valid), 32'd1);
      chk2("b2b data", b32.wb_data, b64.wb_data, {4{4'(i), 4'(i)}});
      chk2("b2b wreg", 32'(b32.wb_wreg), 32'(b64.wb_wreg), 32'(i));
      resp_data = 64'({4{4'(i + 1), 4'(i + 1)}});
    end
    resp_valid = 1'b0;
    tick();
    chk2("drain valid", 32'(b32.wb_valid), 32'(b64.wb_valid), 32'd0);
    chk2("drain count", 32'(cnt32), 32'(cnt64), 32'd0);

    // Simultaneous push and pop
    issue(3'd4, 3'd0, 32'h0, 5'd20, 1'b0);
    req_valid = 1'b1; req_wreg = 5'd21;
    resp_valid = 1'b1; resp_data = 64'hA5A5A5A5;
    tick();
    req_valid = 1'b0; resp_valid = 1'b0;
    chk2("pp count", 32'(cnt32), 32'(cnt64), 32'd1);
    chk2("pp data", b32.wb_data, b64.wb_data, 32'hA5A5A5A5);
    chk2("pp wreg", 32'(b32.wb_wreg), 32'(b64.wb_wreg), 32'd20);
    respond(64'h5A5A5A5A, 1'b0);
    chk2("pp2 wreg", 32'(b32.wb_wreg), 32'(b64.wb_wreg), 32'd21);
    chk2("pp2 count", 32'(cnt32), 32'(cnt64), 32'd0);

    // Flush with three outstanding
    for (int i = 0; i < 3; i++) issue(3'd4, 3'd0, 32'h0, 5'(5 + i), 1'b0);
    flush = 1'b1;
    #1;
    chk2("fl req_ready", 32'(b32.req_ready), 32'(b64.req_ready), 32'd0);
    tick();
    flush = 1'b0;
    #1;
    chk2("fl count", 32'(cnt32), 32'(cnt64), 32'd0);
    chk2("fl wb_valid", 32'(b32.wb_valid), 32'(b64.wb_valid), 32'd0);
    chk2("fl req_ready1", 32'(b32.req_ready), 32'(b64.req_ready), 32'd1);
    issue(3'd1, 3'd0, 32'h0, 5'd9, 1'b0);
    chk2("fl push count", 32'(cnt32), 32'(cnt64), 32'd1);
    chk2("fl refuse rdy", 32'(b32.req_ready), 32'(b64.req_ready), 32'd0);
    req_valid = 1'b1; req_wreg = 5'd30;
    tick();
    req_valid = 1'b0;
    chk2("fl refused", 32'(cnt32), 32'(cnt64), 32'd1);
    resp_valid = 1'b1; resp_data = 64'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk2("drop resp_ready", 32'(b32.resp_ready), 32'(b64.resp_ready), 32'd1);
      tick();
      chk2("drop wb_valid", 32'(b32.wb_valid), 32'(b64.wb_valid), 32'd0);
      chk2("drop count", 32'(cnt32), 32'(cnt64), 32'd1);
    end
    resp_valid = 1'b0;
    #1;
    chk2("post drop rdy", 32'(b32.req_ready), 32'(b64.req_ready), 32'd1);
    respond(64'h000000C3, 1'b0);
    chk2("post drop valid", 32'(b32.wb_valid), 32'(b64.wb_valid), 32'd1);
    chk2("post drop data", b32.wb_data, b64.wb_data, 32'h000000C3);
    chk2("post drop wreg", 32'(b32.wb_wreg), 32'(b64.wb_wreg), 32'd9);
    tick();

    // Asynchronous reset mid-operation
    issue(3'd4, 3'd0, 32'h0, 5'd1, 1'b0);
    chk2("ar pre count", 32'(cnt32), 32'(cnt64), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk2("ar count", 32'(cnt32), 32'(cnt64), 32'd0);
    chk2("ar resp_ready", 32'(b32.resp_ready), 32'(b64.resp_ready), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
